relay_framer: RTL and testbench

- Parametrised successor of the fixed-pattern relay controller in the hi_simulate path.
- Samples the relayed serial bitstream at a divided rate and detects configurable start/end-of-communication patterns.
- Drives mod_type so the analog front end switches between listen and modulate for the fake-reader and fake-tag relay modes.
- Adds a run-time pattern interface, a synchronizer, byte-aligned end detection, a frame-length timeout, a delayed data tap and status outputs.

---
 rtl/relay_pkg.sv | 40 ++++
 rtl/relay_sampler.sv | 82 ++++++++
 rtl/relay_framer.sv | 146 ++++++++++++++
 tb/tb_relay_framer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared mode codes, default patterns and state type for the relay framer
package relay_pkg;

    // Front-end mode codes
    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;
    localparam logic [2:0] FAKE_READER   = 3'b101;
    localparam logic [2:0] FAKE_TAG      = 3'b110;

    // Default start/end-of-communication patterns
    localparam logic [7:0]  READER_START = 8'hc0;
    localparam logic [15:0] READER_END_1 = 16'h0000;
    localparam logic [15:0] READER_END_2 = 16'hc000;
    localparam logic [7:0]  TAG_START    = 8'hf0;
    localparam logic [15:0] TAG_END      = 16'h0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // True for the two relay modes that run the sampler and framer
    function automatic logic is_fake(input logic [2:0] mode);
        return (mode == FAKE_READER) || (mode == FAKE_TAG);
    endfunction

    // Listen code the front end uses while waiting for a frame
    function automatic logic [2:0] listen_code(input logic [2:0] mode);
        return (mode == FAKE_READER) ? READER_LISTEN : TAGSIM_LISTEN;
    endfunction

    // Modulate code the front end uses while a frame is being relayed
    function automatic logic [2:0] mod_code(input logic [2:0] mode);
        return (mode == FAKE_READER) ? READER_MOD : TAGSIM_MOD;
    endfunction

endpackage

// File: rtl/relay_sampler.sv
// rtl/relay_sampler.sv - synchronizer, sample divider, tick generation and receive shift register
module relay_sampler
    import relay_pkg::*;
#(
    parameter int DIV_LOG2  = 4,
    parameter int DIV_PHASE = 8,
    parameter int SHIFT_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_data,
    input  logic [2:0]         i_mode,
    input  logic               i_clear,
    input  logic               i_align_clr,
    output logic [SHIFT_W-1:0] o_shift,
    output logic               o_tick,
    output logic [2:0]         o_align
);

    logic                r_sync1;
    logic                r_sync2;
    logic [DIV_LOG2-1:0] r_div;
    logic [SHIFT_W-1:0]  r_shift;
    logic [2:0]          r_align;
    logic                r_tick;

    logic w_fire;
    logic w_clear;

    // Sampling happens on the edge where the divider sits on the phase; the
    // registered tick then marks the cycle in which the new shift value is visible.
    assign w_fire  = (r_div == DIV_LOG2'(DIV_PHASE)) && is_fake(i_mode);
    assign w_clear = i_clear || !is_fake(i_mode);

    // Two-flop synchronizer for the asynchronous relayed bitstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_data;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Shift register, byte alignment counter and tick pulse; clearing wins over sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_align <= '0;
            r_tick  <= 1'b0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_align <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_fire;
            if (w_fire) begin
                r_shift <= {r_shift[SHIFT_W-2:0], r_sync2};
            end
            if (i_align_clr) begin
                r_align <= '0;
            end else if (w_fire) begin
                r_align <= r_align + 1'b1;
            end
        end
    end

    assign o_shift = r_shift;
    assign o_tick  = r_tick;
    assign o_align = r_align;

endmodule

// File: rtl/relay_framer.sv
// rtl/relay_framer.sv - relay framing FSM driving the analog front-end mode
module relay_framer
    import relay_pkg::*;
#(
    parameter int DIV_LOG2       = 4,
    parameter int DIV_PHASE      = 8,
    parameter int SHIFT_W        = 24,
    parameter int START_W        = 8,
    parameter int END_W          = 16,
    parameter int DATA_TAP       = 7,
    parameter int MAX_FRAME_BITS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    input  logic [2:0]         hi_simulate_mod_type,
    input  logic [START_W-1:0] start_pattern,
    input  logic [END_W-1:0]   end_pattern_a,
    input  logic [END_W-1:0]   end_pattern_b,
    input  logic               end_b_en,
    output logic [2:0]         mod_type,
    output logic               data_out,
    output logic               bit_strobe,
    output logic               frame_active,
    output logic               timeout_flag
);

    localparam int             FC_W   = $clog2(MAX_FRAME_BITS + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(MAX_FRAME_BITS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_req_mode;
    logic [2:0]      r_mod;
    logic [2:0]      w_mod_nxt;
    logic [FC_W-1:0] r_frame_cnt;
    logic [FC_W-1:0] w_frame_nxt;
    logic [FC_W-1:0] w_frame_inc;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            w_align_clr;

    logic               w_fake;
    logic               w_mode_chg;
    logic               w_start_hit;
    logic               w_end_hit;
    logic [SHIFT_W-1:0] w_shift;
    logic               w_tick;
    logic [2:0]         w_align;

    relay_sampler #(
        .DIV_LOG2  (DIV_LOG2),
        .DIV_PHASE (DIV_PHASE),
        .SHIFT_W   (SHIFT_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (reset),
        .i_data      (data_in),
        .i_mode      (hi_simulate_mod_type),
        .i_clear     (w_mode_chg),
        .i_align_clr (w_align_clr),
        .o_shift     (w_shift),
        .o_tick      (w_tick),
        .o_align     (w_align)
    );

    assign w_fake      = is_fake(hi_simulate_mod_type);
    assign w_mode_chg  = (hi_simulate_mod_type != r_req_mode);
    assign w_start_hit = (w_shift == {{(SHIFT_W-START_W){1'b0}}, start_pattern});
    // End patterns are only honoured on byte boundaries counted from the start match
    assign w_end_hit   = (w_align == 3'd0) &&
                         ((w_shift[END_W+7:0] == {end_pattern_a, 8'h00}) ||
                          (end_b_en && (w_shift[END_W+7:0] == {end_pattern_b, 8'h00})));
    assign w_frame_inc = (r_frame_cnt == FC_MAX) ? FC_MAX : r_frame_cnt + 1'b1;

    // Next-state and next-output logic; a mode change or passthrough overrides framing
    always_comb begin
        w_state_nxt   = r_state;
        w_mod_nxt     = r_mod;
        w_frame_nxt   = r_frame_cnt;
        w_timeout_nxt = r_timeout;
        w_align_clr   = 1'b0;
        if (!w_fake) begin
            w_state_nxt = IDLE;
            w_mod_nxt   = hi_simulate_mod_type;
            w_frame_nxt = '0;
        end else if (w_mode_chg) begin
            w_state_nxt = IDLE;
            w_mod_nxt   = listen_code(hi_simulate_mod_type);
            w_frame_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_mod_nxt = listen_code(hi_simulate_mod_type);
                    if (w_tick && w_start_hit) begin
                        w_state_nxt   = ACTIVE;
                        w_mod_nxt     = mod_code(hi_simulate_mod_type);
                        w_align_clr   = 1'b1;
                        w_frame_nxt   = '0;
                        w_timeout_nxt = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (w_tick) begin
                        w_frame_nxt = w_frame_inc;
                        if (w_end_hit) begin
                            w_state_nxt = IDLE;
                            w_mod_nxt   = listen_code(hi_simulate_mod_type);
                        end else if (w_frame_inc == FC_MAX) begin
                            w_state_nxt   = IDLE;
                            w_mod_nxt     = listen_code(hi_simulate_mod_type);
                            w_timeout_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters, requested-mode history and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_mode  <= SNIFFER;
            r_mod       <= SNIFFER;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_mode  <= hi_simulate_mod_type;
            r_mod       <= w_mod_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign mod_type     = r_mod;
    assign data_out     = w_shift[DATA_TAP];
    assign bit_strobe   = w_tick;
    assign frame_active = (r_state == ACTIVE);
    assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_relay_framer.sv
// tb/tb_relay_framer.sv - randomized self-checking bench for relay_framer
module tb_relay_framer;
    import relay_pkg::*;

    localparam int DIV_LOG2  = 4;
    localparam int DIV_PHASE = 8;
    localparam int SHIFT_W   = 24;
    localparam int START_W   = 8;
    localparam int END_W     = 16;
    localparam int DATA_TAP  = 7;
    localparam int MAXF      = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_in = 1'b0;
    logic [2:0]  hi_mode = FAKE_READER;
    logic [7:0]  start_pattern = READER_START;
    logic [15:0] end_a = READER_END_1;
    logic [15:0] end_b = READER_END_2;
    logic        end_b_en = 1'b1;
    logic [2:0]  mod_type;
    logic        data_out;
    logic        bit_strobe;
    logic        frame_active;
    logic        timeout_flag;

    relay_framer #(
        .DIV_LOG2(DIV_LOG2), .DIV_PHASE(DIV_PHASE), .SHIFT_W(SHIFT_W), .START_W(START_W),
        .END_W(END_W), .DATA_TAP(DATA_TAP), .MAX_FRAME_BITS(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .hi_simulate_mod_type(hi_mode),
        .start_pattern(start_pattern), .end_pattern_a(end_a), .end_pattern_b(end_b),
        .end_b_en(end_b_en), .mod_type(mod_type), .data_out(data_out),
        .bit_strobe(bit_strobe), .frame_active(frame_active), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample history since the last clear plus frame bookkeeping
    bit         mq[$];
    int         m_since = 0;
    bit         m_active = 0;
    bit         m_timeout = 0;
    logic [2:0] m_mode = FAKE_READER;

    function automatic bit fake(input logic [2:0] m);
        return (m == 3'b101) || (m == 3'b110);
    endfunction

    function automatic logic [2:0] exp_mod_type();
        if (!fake(m_mode)) return m_mode;
        if (m_mode == 3'b101) return m_active ? 3'b100 : 3'b011;
        return m_active ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [23:0] m_window();
        logic [23:0] v = '0;
        for (int i = 0; i < 24; i++)
            if (i < mq.size()) v[i] = mq[mq.size() - 1 - i];
        return v;
    endfunction

    function automatic bit exp_dout();
        if (mq.size() > DATA_TAP) return mq[mq.size() - 1 - DATA_TAP];
        return 1'b0;
    endfunction

    task automatic model_mode(input logic [2:0] m);
        if (m !== m_mode) begin
            mq.delete();
            m_active = 0;
            m_mode   = m;
        end
    endtask

    task automatic model_tick(input bit b);
        logic [23:0] w;
        mq.push_back(b);
        if (mq.size() > 32) mq.delete(0);
        w = m_window();
        if (!m_active) begin
            if (w == {16'h0000, start_pattern}) begin
                m_active  = 1;
                m_since   = 0;
                m_timeout = 0;
            end
        end else begin
            m_since++;
            if ((m_since % 8 == 0) && (w == {end_a, 8'h00} || (end_b_en && w == {end_b, 8'h00})))
                m_active = 0;
            else if (m_since >= MAXF) begin
                m_active  = 0;
                m_timeout = 1;
            end
        end
    endtask

    // Called 1ns after a sample edge; leaves the bench 1ns after the following edge
    task automatic tick_check(input bit b);
        chk("bit_strobe", bit_strobe, 1);
        model_tick(b);
        chk("data_out", data_out, exp_dout());
        @(posedge clk); #1;
        chk("strobe_low", bit_strobe, 0);
        chk("mod_type", mod_type, exp_mod_type());
        chk("frame_active", frame_active, m_active);
        chk("timeout_flag", timeout_flag, m_timeout);
    endtask

    task automatic sample(input bit b);
        data_in = b;
        repeat (15) @(posedge clk);
        #1;
        tick_check(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) sample(t[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) sample(1'b0);
    endtask

    task automatic set_mode(input logic [2:0] m);
        hi_mode = m;
        if (m == FAKE_READER) begin
            start_pattern = READER_START; end_a = READER_END_1; end_b = READER_END_2;
        end else if (m == FAKE_TAG) begin
            start_pattern = TAG_START; end_a = TAG_END; end_b = TAG_END;
        end
        model_mode(m);
    endtask

    task automatic pass_period(input logic [2:0] m, input int n);
        hi_mode = m;
        model_mode(m);
        @(posedge clk); #1;
        chk("pt_mod_type", mod_type, exp_mod_type());
        chk("pt_frame_active", frame_active, 0);
        chk("pt_timeout", timeout_flag, m_timeout);
        repeat (16 * n - 1) begin
            @(posedge clk); #1;
            chk("pt_strobe", bit_strobe, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_mod_type", mod_type, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_timeout", timeout_flag, 0);
        chk("rst_strobe", bit_strobe, 0);
        data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_active  = 0;
        m_timeout = 0;
        m_mode    = hi_mode;
        repeat (9) @(posedge clk);
        #1;
        tick_check(1'b0);
    endtask

    initial begin
        logic [2:0] pm;
        logic [7:0] sb;
        #2;
        do_reset();

        // Reader start, then end via the secondary pattern on a byte boundary
        send_zeros(16); send_byte(8'hc0);
        send_byte(8'hc0); send_zeros(24);
        // Same end pattern displaced by three samples
        send_zeros(16); send_byte(8'hc0); send_zeros(3); send_byte(8'hc0); send_zeros(24);

        // Tag start, payload and aligned end; then secondary pattern disabled
        set_mode(FAKE_TAG); end_b_en = 1'b0;
        send_zeros(16); send_byte(8'hf0); send_byte(8'ha5); send_zeros(24);
        end_b = 16'hc000;
        send_zeros(16); send_byte(8'hf0); send_byte(8'hc0); send_byte(8'h00); send_zeros(16);

        // Frame-length timeout, then a new start clears the flag
        set_mode(FAKE_READER); end_b_en = 1'b1;
        send_zeros(16); send_byte(8'hc0);
        for (int i = 0; i < 40; i++) sample(i[0] ? 1'b0 : 1'b1);
        send_zeros(16); send_byte(8'hc0); send_zeros(8);

        // Mid-frame switch to passthrough, then back
        send_zeros(16); send_byte(8'hc0); send_byte(8'h5a);
        pass_period(TAGSIM_MOD, 2);
        set_mode(FAKE_READER);
        send_zeros(16); send_byte(8'hc0); send_zeros(24);

        // Mid-frame switch between relay modes
        send_zeros(16); send_byte(8'hc0); sample(1'b1); sample(1'b0); sample(1'b1);
        set_mode(FAKE_TAG);
        send_zeros(16); send_byte(8'hf0); send_zeros(24);

        // Reset mid-frame, then delayed data tap on random samples
        set_mode(FAKE_READER);
        send_zeros(16); send_byte(8'hc0); send_byte(8'h3c);
        do_reset();
        for (int i = 0; i < 20; i++) sample(1'($urandom));

        // Randomized frames, mode switches, passthrough periods and resets
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    pm = 3'($urandom_range(0, 5));
                    if (pm == 3'd5) pm = 3'd7;
                    pass_period(pm, 1 + $urandom_range(0, 1));
                end
                1: begin
                    if (!fake(hi_mode)) set_mode(FAKE_READER);
                    do_reset();
                end
                default: ;
            endcase
            set_mode($urandom_range(0, 1) ? FAKE_READER : FAKE_TAG);
            end_b_en = 1'($urandom);
            send_zeros(16 + $urandom_range(0, 3));
            sb = start_pattern;
            if ($urandom_range(0, 4) == 0) sb = sb ^ (8'h01 << $urandom_range(0, 7));
            send_byte(sb);
            for (int j = 0, n = $urandom_range(0, 32); j < n; j++) sample(1'($urandom));
            if ($urandom_range(0, 1) == 1) send_zeros($urandom_range(16, 26));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
